// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
//   mem_address     word-aligned access address
//   mem_wdata       byte-lane-replicated store data
//   mem_byte_enable active byte lanes for reads and writes
//   mem_read        read request strobe, held until mem_ack or timeout
//   mem_write       write request strobe, held until mem_ack or timeout
//   mem_rdata       read data, valid with mem_ack
//   mem_ack         completes the outstanding request
interface load_store_unit_if;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    output mem_read,
    output mem_write,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    input  mem_read,
    input  mem_write,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: runs one byte/half/word data-memory access per start with a
// request/acknowledge handshake, an acknowledge timeout and a one-cycle done pulse.
//
// Optional feature macro: LSU_MISALIGNED_TRAP_EN
//   defined   - misaligned accesses and size=11 skip the bus and complete with error
//   undefined - offset bits below the access alignment are dropped; size=11 is a word
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   start          begin an access (sampled only when idle)
//   store          1 = store, 0 = load
//   size           00 byte, 01 half, 10 word, 11 reserved
//   load_unsigned  zero-extend loads instead of sign-extend
//   address        access address; bits [31:2] used
//   data_offset    byte offset, sampled one cycle after start
//   store_data     store value (low bits for byte/half)
//   load_data      aligned, extended load result; holds until the next good load
//   busy           access in progress
//   done, error    one-cycle completion pulse and failure flag
//   bus            data-memory bus (master side)
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              store,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [31:0]       address,
  input  logic [1:0]        data_offset,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  load_store_unit_if.master bus
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StRequest, StWait, StRespond} state_e;

  state_e            state_q;
  logic              store_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [31:0]       store_data_q;
  logic [1:0]        offset_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic [31:0]       load_data_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [31:0]       mem_address_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_be_q;
  logic              mem_read_q;
  logic              mem_write_q;

  // Lane computation from the captured size and the live data_offset (REQUEST only).
  logic [1:0]  eff_offset;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        misaligned;
  logic        trap;

  always_comb begin
    misaligned = 1'b0;
    eff_offset = 2'b00;
    lane_be    = 4'b1111;
    lane_wdata = store_data_q;
    case (size_q)
      2'b00: begin
        eff_offset = data_offset;
        lane_be    = 4'b0001 << data_offset;
        lane_wdata = {4{store_data_q[7:0]}};
      end
      2'b01: begin
        misaligned = data_offset[0];
        eff_offset = {data_offset[1], 1'b0};
        lane_be    = 4'b0011 << {data_offset[1], 1'b0};
        lane_wdata = {2{store_data_q[15:0]}};
      end
      2'b10: begin
        misaligned = (data_offset != 2'b00);
      end
      default: begin
        // Reserved size: always a trap candidate, otherwise behaves as a word.
        misaligned = 1'b1;
      end
    endcase
  end

`ifdef LSU_MISALIGNED_TRAP_EN
  assign trap = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign trap = 1'b0;
`endif

  // Load extraction from the bus read data using the registered effective offset.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    byte_sel = bus.mem_rdata[{offset_q, 3'b000} +: 8];
    half_sel = bus.mem_rdata[{offset_q[1], 4'b0000} +: 16];
    load_ext = bus.mem_rdata;
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = unsigned_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  logic timeout_hit;
  assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt_q == CntW'(ACK_TIMEOUT - 1));

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^address[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      store_q       <= 1'b0;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      store_data_q  <= 32'b0;
      offset_q      <= 2'b00;
      wait_cnt_q    <= '0;
      load_data_q   <= 32'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      mem_address_q <= 32'b0;
      mem_wdata_q   <= 32'b0;
      mem_be_q      <= 4'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            store_q       <= store;
            size_q        <= size;
            unsigned_q    <= load_unsigned;
            store_data_q  <= store_data;
            mem_address_q <= {address[31:2], 2'b00};
            busy_q        <= 1'b1;
            state_q       <= StRequest;
          end
        end
        StRequest: begin
          offset_q <= eff_offset;
          if (trap) begin
            // Never reaches the bus; strobes stay low and load_data is untouched.
            done_q  <= 1'b1;
            error_q <= 1'b1;
            state_q <= StRespond;
          end else begin
            mem_be_q    <= lane_be;
            mem_wdata_q <= lane_wdata;
            mem_read_q  <= ~store_q;
            mem_write_q <= store_q;
            wait_cnt_q  <= '0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (bus.mem_ack) begin
            if (!store_q) begin
              load_data_q <= load_ext;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StRespond;
          end else if (timeout_hit) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b1;
            error_q     <= 1'b1;
            state_q     <= StRespond;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StRespond: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign load_data           = load_data_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_byte_enable = mem_be_q;
  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases plus randomized
// accesses checked against a byte-arithmetic reference model.
module tb_load_store_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        store;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [1:0]  data_offset;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        error;

  load_store_unit_if bus_if ();

  load_store_unit #(.ACK_TIMEOUT(15)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .store         (store),
    .size          (size),
    .load_unsigned (load_unsigned),
    .address       (address),
    .data_offset   (data_offset),
    .store_data    (store_data),
    .load_data     (load_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .bus           (bus_if.master)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] ld_exp;  // what load_data must currently hold

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: an access touches nb bytes starting at an nb-aligned offset.
  function automatic void model(input bit [1:0] sz, input bit uns, input bit [1:0] off,
                                input bit [31:0] sdata, input bit [31:0] rdata,
                                output bit [3:0] be, output bit [31:0] wd,
                                output bit [31:0] ld, output bit trap);
    int nb;
    int o;
    logic [63:0] mask;
    logic [63:0] val;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    o = int'(off);
    trap = 1'b0;
`ifdef LSU_MISALIGNED_TRAP_EN
    trap = (sz == 2'd3) || (o % nb != 0);
`endif
    o = (o / nb) * nb;
    be = 4'(((1 << nb) - 1) << o);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sdata[8*(i % nb) +: 8];
    mask = (64'd1 << (8 * nb)) - 64'd1;
    val = (64'(rdata) >> (8 * o)) & mask;
    if (!uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
    ld = val[31:0];
  endfunction

  // One access from IDLE. ack_at = WAIT cycle index (0 = first) of the ack, <0 = none.
  // poke = keep start asserted with other fields while busy.
  task automatic run_access(input bit st, input bit [1:0] sz, input bit uns,
                            input bit [31:0] addr, input bit [1:0] off,
                            input bit [31:0] sdata, input bit [31:0] rdata,
                            input int ack_at, input bit poke);
    bit [3:0]  e_be;
    bit [31:0] e_wd;
    bit [31:0] e_ld;
    bit        trap;
    int        k;
    int        exp_len;
    bit        stable;
    model(sz, uns, off, sdata, rdata, e_be, e_wd, e_ld, trap);
    check("busy_idle", busy, 1'b0);
    start = 1'b1; store = st; size = sz; load_unsigned = uns;
    address = addr; data_offset = off; store_data = sdata;
    step();  // cycle 1: REQUEST
    start = poke; store = 1'b0; size = 2'b00; store_data = 32'hA5A5A5A5;
    address = $urandom;
    check("busy_req", busy, 1'b1);
    check("strobe_req", {30'b0, bus_if.mem_read, bus_if.mem_write}, 32'b0);
    step();  // cycle 2
    data_offset = 2'($urandom);
    if (trap) begin
      check("trap_done", {30'b0, done, error}, 32'd3);
      check("trap_strobe", {30'b0, bus_if.mem_read, bus_if.mem_write}, 32'b0);
      check("trap_ld", load_data, ld_exp);
      start = 1'b0;
    end else begin
      check("wait_done", done, 1'b0);
      check("wait_strobe", {30'b0, bus_if.mem_read, bus_if.mem_write}, {30'b0, ~st, st});
      check("wait_addr", bus_if.mem_address, {addr[31:2], 2'b00});
      check("wait_be", {28'b0, bus_if.mem_byte_enable}, {28'b0, e_be});
      if (st) check("wait_wdata", bus_if.mem_wdata, e_wd);
      k = 0;
      stable = 1'b1;
      while ((bus_if.mem_read || bus_if.mem_write) && k < 40) begin
        stable &= (bus_if.mem_byte_enable == e_be) &&
                  (bus_if.mem_address == {addr[31:2], 2'b00});
        if (k == ack_at) begin
          bus_if.mem_ack = 1'b1;
          bus_if.mem_rdata = rdata;
        end
        step();
        bus_if.mem_ack = 1'b0;
        bus_if.mem_rdata = $urandom;
        k++;
      end
      start = 1'b0;
      exp_len = (ack_at >= 0) ? ack_at + 1 : 15;
      check("wait_len", k, exp_len);
      check("wait_stable", stable, 1'b1);
      check("resp_done", {30'b0, done, error}, {30'b0, 1'b1, ack_at < 0});
      if (!st && ack_at >= 0) ld_exp = e_ld;
      check("resp_ld", load_data, ld_exp);
    end
    step();  // back in IDLE
    check("post_flags", {29'b0, busy, done, error}, 32'b0);
  endtask

  initial begin
    bit        nodone;
    bit [1:0]  r_sz;
    bit [1:0]  r_off;
    reset = 1'b1; start = 1'b0; store = 1'b0; size = 2'b00; load_unsigned = 1'b0;
    address = 32'b0; data_offset = 2'b00; store_data = 32'b0;
    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'b0;
    ld_exp = 32'b0;
    step();
    step();
    check("rst_flags", {29'b0, busy, done, error}, 32'b0);
    check("rst_ld", load_data, 32'b0);
    check("rst_bus", {bus_if.mem_address ^ bus_if.mem_wdata, 26'b0}, 58'b0);
    check("rst_be_strobe", {26'b0, bus_if.mem_byte_enable, bus_if.mem_read, bus_if.mem_write},
          32'b0);
    reset = 1'b0;
    step();

    // Signed then unsigned byte load at offset 3.
    run_access(1'b0, 2'b00, 1'b0, 32'h100, 2'd3, 32'b0, 32'h80FF1234, 0, 1'b0);
    check("tp_byte_s", load_data, 32'hFFFFFF80);
    check("tp_byte_be", {28'b0, bus_if.mem_byte_enable}, 32'h8);
    check("tp_byte_addr", bus_if.mem_address, 32'h100);
    run_access(1'b0, 2'b00, 1'b1, 32'h100, 2'd3, 32'b0, 32'h80FF1234, 0, 1'b0);
    check("tp_byte_u", load_data, 32'h00000080);

    // Half store at offset 2, ack after three WAIT cycles.
    run_access(1'b1, 2'b01, 1'b0, 32'h200, 2'd2, 32'h0000BEEF, 32'b0, 2, 1'b0);
    check("tp_half_wd", bus_if.mem_wdata, 32'hBEEFBEEF);
    check("tp_half_be", {28'b0, bus_if.mem_byte_enable}, 32'hC);

    // Misaligned word load.
    run_access(1'b0, 2'b10, 1'b0, 32'h300, 2'd1, 32'b0, 32'hCAFEF00D, 0, 1'b0);
`ifdef LSU_MISALIGNED_TRAP_EN
    check("tp_mis_ld", load_data, 32'hFFFFFF80 & 32'h000000FF);
`else
    check("tp_mis_ld", load_data, 32'hCAFEF00D);
`endif

    // Timeout, then a late ack must be ignored.
    run_access(1'b0, 2'b10, 1'b0, 32'h340, 2'd0, 32'b0, 32'h11111111, -1, 1'b0);
    bus_if.mem_ack = 1'b1;
    bus_if.mem_rdata = 32'h22222222;
    nodone = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      nodone &= !done && !busy;
    end
    bus_if.mem_ack = 1'b0;
    check("late_ack_idle", nodone, 1'b1);
    check("late_ack_ld", load_data, ld_exp);

    // Reset in the middle of WAIT.
    start = 1'b1; store = 1'b0; size = 2'b00; address = 32'h500; data_offset = 2'd1;
    step();
    start = 1'b0;
    step();
    check("mid_wait_read", bus_if.mem_read, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_strobe", {30'b0, bus_if.mem_read, bus_if.mem_write}, 32'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ld", load_data, 32'b0);
    check("rst_mid_be", {28'b0, bus_if.mem_byte_enable}, 32'b0);
    ld_exp = 32'b0;
    step();
    reset = 1'b0;
    step();
    run_access(1'b0, 2'b00, 1'b0, 32'h600, 2'd1, 32'b0, 32'h00007F00, 0, 1'b0);
    check("after_rst_ld", load_data, 32'h0000007F);

    // start held high while busy: one access only, with the first captured fields.
    run_access(1'b1, 2'b10, 1'b0, 32'h400, 2'd0, 32'h12345678, 32'b0, 1, 1'b1);
    nodone = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      nodone &= !done && !busy;
    end
    check("poke_single", nodone, 1'b1);
    check("poke_wdata", bus_if.mem_wdata, 32'h12345678);

    // Randomized accesses.
    for (int n = 0; n < 24; n++) begin
      r_sz = 2'($urandom);
      r_off = 2'($urandom);
      run_access(1'($urandom), r_sz, 1'($urandom), $urandom, r_off, $urandom, $urandom,
                 int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage that sits directly downstream of `program_counter`. It takes the forwarded data address and the registered `data_offset`, runs one byte/half/word transaction on the data-memory bus with a request/acknowledge handshake, and returns sign- or zero-extended load data or byte-lane-replicated store data. It guarantees one outstanding access, a bounded wait (acknowledge timeout) and a single-cycle completion pulse to the control unit.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 15: number of WAIT cycles allowed without `mem_ack` before a bus error; 0 disables the timeout.

Ports:
- `clock`  in  1  single clock; everything is on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  begin an access; sampled only in IDLE.
- `store`  in  1  1 = store, 0 = load; captured with `start`.
- `size`  in  2  00 byte, 01 half, 10 word, 11 reserved; captured with `start`.
- `load_unsigned`  in  1  zero-extend instead of sign-extend; captured with `start`.
- `address`  in  32  from `program_counter.address_bus`; bits [31:2] captured with `start`.
- `data_offset`  in  2  from `program_counter.data_offset`; captured in REQUEST.
- `store_data`  in  32  captured with `start`.
- `load_data`  out  32  aligned and extended load result; holds until the next load completes.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse in RESPOND.
- `error`  out  1  one-cycle pulse in RESPOND when the access failed.
- `mem_address`  out  32  {captured[31:2], 2'b00}.
- `mem_wdata`  out  32  replicated store data.
- `mem_byte_enable`  out  4  active byte lanes, for both reads and writes.
- `mem_read`, `mem_write`  out  1  request strobes, high only in WAIT.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.
- `mem_ack`  in  1  completes the request; sampled only in WAIT.

## Operation
- States: IDLE, REQUEST, WAIT, RESPOND.
- IDLE: on `start`, capture the inputs listed above and go to REQUEST. `start` is ignored in every other state.
- REQUEST: capture `data_offset`, then compute the lanes:
  - byte: 4'b0001 << offset.
  - half: 4'b0011 << {offset[1], 1'b0}.
  - word: 4'b1111.
  - Store data: byte drives {4{d[7:0]}}, half drives {2{d[15:0]}}, word drives d.
  - A misaligned access (half with offset[0]=1, word with offset≠0) or size=11 is handled per Configuration.
  - Otherwise go to WAIT.
- WAIT: `mem_read`/`mem_write` stay high. On `mem_ack`, latch `mem_rdata` for loads and go to RESPOND.
  - A wait counter, cleared on entering WAIT, increments each WAIT cycle without ack.
  - When the counter equals `ACK_TIMEOUT`-1 and there is no ack, go to RESPOND with error. The strobes drop, and a late ack is ignored.
- RESPOND: pulse `done`, plus `error` if flagged, then go to IDLE.
  - `load_data` updates only for a successful load.
  - Load extraction: byte = rdata >> (8*offset); half = rdata >> (16*offset[1]); extend per `load_unsigned`. `load_unsigned` is ignored for words.
- Reset (any state, including mid-WAIT):
  - State goes to IDLE and the strobes drop immediately.
  - These outputs go to 0: `load_data`, `done`, `error`, `busy`, `mem_address`, `mem_wdata`, `mem_byte_enable`.
  - The timeout counter goes to 0.

## Timing
- `start` at cycle 0 → REQUEST at cycle 1 → WAIT at cycle 2 (strobes high).
- An ack at cycle 2 gives RESPOND at cycle 3, with `done` and `load_data` valid at cycle 3. The minimum start-to-done latency is 3 cycles.
- `busy` is high from cycle 1 to RESPOND inclusive. A new `start` is accepted in the cycle after RESPOND.
- `data_offset` must be valid at cycle 1, which matches the registered-offset behaviour of `program_counter`.
- Addresses, byte enables and write data are stable for the whole of WAIT.

## Configuration
- `LSU_MISALIGNED_TRAP_EN` defined:
  - A misaligned access or size=11 skips WAIT and goes REQUEST→RESPOND with `error`=1.
  - No strobe is asserted and `load_data` is unchanged.
- Not defined:
  - Offset bits below the access alignment are forced to 0 (half ignores offset[0]; word ignores the whole offset), and the access proceeds normally.
  - size=11 is treated as a word access; `error` is raised only on timeout.

## Test plan
- Signed byte load: address=0x100, offset=3, rdata=0x80FF1234, ack in the first WAIT cycle → byte_enable=4'b1000, mem_address=0x100, load_data=0xFFFFFF80, `done` at cycle 3. Repeat with `load_unsigned`=1 → 0x00000080.
- Half store: address=0x200, offset=2, store_data=0x0000BEEF → mem_wdata=0xBEEFBEEF, byte_enable=4'b1100, `mem_write` high until ack, `done` with `error`=0.
- Misaligned word load at offset=1:
  - With the macro → no `mem_read`; `done` and `error` at cycle 2.
  - Without it → word read at byte_enable=4'b1111; load_data equals rdata.
- Timeout with ACK_TIMEOUT=15 and no ack → `mem_read` high for exactly 15 cycles, then `error` and `done` pulse, `load_data` unchanged. An ack driven afterwards is ignored.
- Reset asserted mid-WAIT → strobes low and `busy`=0 in the same cycle. A fresh byte load afterwards completes in 3 cycles.
- `start` pulsed while `busy` → ignored. Exactly one `done` for the first access, with its captured size and data.
